// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding, default operand width and counter sizing for mul_seq.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEF_WIDTH = 16;

    // One extra bit so the counter can hold WIDTH itself.
    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mul_acc_add.sv
// mul_acc_add: (WIDTH+1)-bit accumulate adder.
// It is built from chained 4-bit carry-lookahead slices plus a 1-bit top slice.
// Ports: x, y (WIDTH+1 addends), cin (carry-in), sum (WIDTH+1 result, carry-out dropped).
module mul_acc_add import mul_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0] x,
    input  logic [WIDTH:0] y,
    input  logic           cin,
    output logic [WIDTH:0] sum
);

    localparam int N = WIDTH / 4;

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [N:0]       c;

    assign p    = x[WIDTH-1:0] ^ y[WIDTH-1:0];
    assign g    = x[WIDTH-1:0] & y[WIDTH-1:0];
    assign c[0] = cin;

    for (genvar s = 0; s < N; s++) begin : g_cla
        logic [3:0] pp;
        logic [3:0] gg;
        logic [3:0] cc;
        assign pp = p[4*s +: 4];
        assign gg = g[4*s +: 4];
        assign cc[0] = c[s];
        assign cc[1] = gg[0] | (pp[0] & c[s]);
        assign cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[s]);
        assign cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                     | (pp[2] & pp[1] & pp[0] & c[s]);
        assign c[s+1] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                      | (pp[3] & pp[2] & pp[1] & gg[0]) | (&pp & c[s]);
        assign sum[4*s +: 4] = pp ^ cc;
    end

    assign sum[WIDTH] = x[WIDTH] ^ y[WIDTH] ^ c[N];

endmodule

// File: rtl/mul_seq.sv
// mul_seq: sequential shift-and-add multiplier, one multiplier bit per cycle.
// Ports: clk, rst_n (async active-low), start, flush, a (multiplicand), b (multiplier),
//        ready (IDLE only), done (one-cycle pulse), product (2*WIDTH, held).
// MUL_SIGNED_EN: when defined, two's-complement signed multiply; otherwise unsigned.
module mul_seq import mul_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               flush,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state, state_nx;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] q;
    logic [WIDTH:0]   acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   y;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   acc_nx;
    logic [WIDTH-1:0] q_nx;
    logic             cin;
    logic             msb;
    logic             last;
    logic             fin;

    assign last  = cnt == CW'(WIDTH - 1);
    assign ready = state == IDLE;
    assign fin   = state == BUSY && last && !flush;

`ifdef MUL_SIGNED_EN
    // The multiplier's sign bit has negative weight, so the final step subtracts M.
    logic sub;
    assign sub = last & q[0];
    assign y   = q[0] ? ({m[WIDTH-1], m} ^ {(WIDTH+1){sub}}) : '0;
    assign cin = sub;
    assign msb = sum[WIDTH];
`else
    assign y   = q[0] ? {1'b0, m} : '0;
    assign cin = 1'b0;
    assign msb = 1'b0;
`endif

    mul_acc_add #(.WIDTH(WIDTH)) u_add (
        .x   (acc),
        .y   (y),
        .cin (cin),
        .sum (sum)
    );

    // The sum's top bit (carry or sign) lands in the top of the WIDTH-bit accumulator value.
    assign acc_nx = {msb, sum[WIDTH:1]};
    assign q_nx   = {sum[0], q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        state_nx = flush           ? IDLE
                 : state == IDLE   ? (start ? BUSY : IDLE)
                 : state == BUSY   ? (last ? DONE : BUSY)
                 : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m       <= '0;
            q       <= '0;
            acc     <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            if (state == IDLE && start && !flush) begin
                m   <= a;
                q   <= b;
                acc <= '0;
                cnt <= '0;
            end else if (state == BUSY && !flush) begin
                acc <= acc_nx;
                q   <= q_nx;
                cnt <= cnt + 1'b1;
            end
            done <= fin;
            if (fin) product <= {acc_nx[WIDTH-1:0], q_nx};
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: scoreboard bench for mul_seq (expected products queued at accept, checked on done).
module tb_mul_seq;

    localparam int W = 16;

`ifdef MUL_SIGNED_EN
    localparam logic [2*W-1:0] EXP_MAX = 32'h0000_0001;
    localparam logic [2*W-1:0] EXP_SGN = 32'hFFFF_0000;
    localparam logic [2*W-1:0] EXP_NEG = 32'hFFFF_FFEB;
`else
    localparam logic [2*W-1:0] EXP_MAX = 32'hFFFE_0001;
    localparam logic [2*W-1:0] EXP_SGN = 32'h0001_0000;
    localparam logic [2*W-1:0] EXP_NEG = 32'h0006_FFEB;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           flush = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           ready;
    logic           done;
    logic [2*W-1:0] product;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [2*W-1:0] sb[$];

    mul_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .flush   (flush),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] z);
`ifdef MUL_SIGNED_EN
        return {{W{x[W-1]}}, x} * {{W{z[W-1]}}, z};
`else
        return {{W{1'b0}}, x} * {{W{1'b0}}, z};
`endif
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) chk("spurious_done", 1, 0);
            else chk("product", product, sb.pop_front());
        end
    end

    // Called at a negedge while idle; returns at the negedge after the done cycle.
    task automatic mul(input logic [W-1:0] x, input logic [W-1:0] z, output logic [2*W-1:0] res);
        int t0;
        bit seen;
        seen = 0;
        chk("ready_before", ready, 1);
        a = x;
        b = z;
        start = 1'b1;
        sb.push_back(model(x, z));
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        @(negedge clk);
        chk("ready_busy", ready, 0);
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("done_seen", seen, 1);
        if (seen) chk("latency", cyc - t0, W);
        res = product;
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("ready_after", ready, 1);
    endtask

    initial begin
        logic [2*W-1:0] r;
        int prev;
        int n;
        prev = 0;
        n = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_product", product, 0);
        rst_n = 1'b1;
        @(negedge clk);

        mul(16'd3, 16'd5, r);
        chk("basic", r, 32'h0000_000F);
        mul(16'hFFFF, 16'hFFFF, r);
        chk("max", r, EXP_MAX);
        mul(16'h8000, 16'h0002, r);
        chk("sign", r, EXP_SGN);
        mul(16'hFFFD, 16'h0007, r);
        chk("neg", r, EXP_NEG);
        for (int i = 0; i < 4; i++) mul(W'($urandom), W'($urandom), r);

        // flush with an ignored start during BUSY
        mul(16'd3, 16'd5, r);
        a = 16'd7;
        b = 16'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 16'd1;
        b = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignores_start", ready, 0);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_ready", ready, 1);
        chk("flush_done", done, 0);
        chk("flush_product", product, 32'h0000_000F);
        repeat (25) @(negedge clk);
        chk("flush_hold_product", product, 32'h0000_000F);
        chk("flush_idle", ready, 1);

        // reset mid-BUSY
        a = 16'd9;
        b = 16'd11;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", ready, 1);
        chk("midrst_done", done, 0);
        chk("midrst_product", product, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("midrst_idle", ready, 1);

        // back-to-back with start held high
        start = 1'b1;
        for (int i = 0; i < 200 && n < 4; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            if (ready) begin
                sb.push_back(model(a, b));
                if (n > 0) chk("b2b_interval", cyc - prev, W + 2);
                prev = cyc;
                n++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("b2b_accepts", n, 4);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
